uart_mmio_bridge: RTL and testbench

UART_MMIO_BRIDGE -- requirements
Module: uart_mmio_bridge

---
 rtl/uart_mmio_bridge_pkg.sv | 36 +++
 rtl/uart_tx_fifo.sv | 62 ++++++
 rtl/uart_mmio_bridge.sv | 179 +++++++++++++++++
 tb/tb_uart_mmio_bridge.sv | 313 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_mmio_bridge_pkg.sv
// Shared constants for the UART MMIO bridge: register map, STATUS layout,
// RX poll FSM encoding and the STATUS word packing helper.
package uart_mmio_bridge_pkg;

  localparam int CHAR_W = 8;

  localparam logic [3:0] ADDR_TXDATA = 4'h0;
  localparam logic [3:0] ADDR_RXDATA = 4'h4;
  localparam logic [3:0] ADDR_STATUS = 4'h8;

  localparam int STATUS_TX_FULL  = 0;
  localparam int STATUS_TX_EMPTY = 1;
  localparam int STATUS_RX_VALID = 2;

  // Simulator reply meaning "no character available"; also the RXDATA
  // value returned when the receive buffer is empty.
  localparam logic [CHAR_W-1:0] RX_NO_DATA = 8'hFF;

  typedef enum logic [1:0] {
    RX_IDLE = 2'd0,
    RX_WAIT = 2'd1,
    RX_POLL = 2'd2
  } rx_state_e;

  function automatic logic [63:0] status_word(input logic rx_valid,
                                              input logic tx_empty,
                                              input logic tx_full);
    logic [63:0] w;
    w = '0;
    w[STATUS_RX_VALID] = rx_valid;
    w[STATUS_TX_EMPTY] = tx_empty;
    w[STATUS_TX_FULL]  = tx_full;
    return w;
  endfunction

endpackage

// File: rtl/uart_tx_fifo.sv
// Character FIFO between the MMIO store path and the UART emit strobe.
// Pushes while full and pops while empty are ignored.
module uart_tx_fifo
  import uart_mmio_bridge_pkg::*;
#(
  parameter int DEPTH = 8
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic                    push,
  input  logic [CHAR_W-1:0]       push_data,
  input  logic                    pop,
  output logic [CHAR_W-1:0]       pop_data,
  output logic                    full,
  output logic                    empty,
  output logic [$clog2(DEPTH):0]  count
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam logic [PTR_W:0] FULL_COUNT = (PTR_W + 1)'(DEPTH);

  logic [CHAR_W-1:0] mem [DEPTH];
  logic [PTR_W-1:0]  wr_ptr;
  logic [PTR_W-1:0]  rd_ptr;
  logic              do_push;
  logic              do_pop;

  assign full     = (count == FULL_COUNT);
  assign empty    = (count == '0);
  assign do_push  = push && !full;
  assign do_pop   = pop && !empty;
  assign pop_data = mem[rd_ptr];

  // Character storage; contents need no reset because count guards reads.
  always_ff @(posedge clock) begin
    if (do_push) begin
      mem[wr_ptr] <= push_data;
    end
  end

  // Pointers wrap naturally at DEPTH; count tracks occupancy for full/empty.
  always_ff @(posedge clock) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) begin
        wr_ptr <= wr_ptr + PTR_W'(1);
      end
      if (do_pop) begin
        rd_ptr <= rd_ptr + PTR_W'(1);
      end
      case ({do_push, do_pop})
        2'b10:   count <= count + (PTR_W + 1)'(1);
        2'b01:   count <= count - (PTR_W + 1)'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/uart_mmio_bridge.sv
// MMIO front end for a simulated UART: TXDATA stores are queued and emitted
// with a minimum spacing, the simulator is polled for input while the RX
// buffer is empty, and loads return TXDATA/RXDATA/STATUS one cycle later.
module uart_mmio_bridge
  import uart_mmio_bridge_pkg::*;
#(
  parameter int TX_DEPTH = 8,
  parameter int TX_GAP   = 2,
  parameter int POLL_GAP = 4
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        req_valid,
  input  logic        req_write,
  input  logic [3:0]  req_addr,
  input  logic [7:0]  req_wdata,
  output logic        req_ready,
  output logic        rsp_valid,
  output logic [63:0] rsp_rdata,
  output logic        uart_out_valid,
  output logic [7:0]  uart_out_ch,
  output logic        uart_in_valid,
  input  logic [7:0]  uart_in_ch
);

  localparam int GAP_W     = (TX_GAP > 1) ? $clog2(TX_GAP) : 1;
  localparam int WAIT_W    = (POLL_GAP > 1) ? $clog2(POLL_GAP) : 1;
  localparam int WAIT_LOAD = (POLL_GAP > 1) ? POLL_GAP - 2 : 0;
  localparam logic [GAP_W-1:0]  GAP_RELOAD  = GAP_W'(TX_GAP - 1);
  localparam logic [WAIT_W-1:0] WAIT_RELOAD = WAIT_W'(WAIT_LOAD);

  logic                       handshake;
  logic                       is_load;
  logic                       tx_push;
  logic                       tx_pop;
  logic                       tx_full;
  logic                       tx_empty;
  logic [$clog2(TX_DEPTH):0]  tx_count;
  logic [CHAR_W-1:0]          tx_pop_data;
  logic [GAP_W-1:0]           gap_cnt;

  logic                       rx_valid;
  logic [CHAR_W-1:0]          rx_buf;
  logic                       rx_clear;
  logic                       poll_load;
  logic [63:0]                load_data;

  rx_state_e                  state;
  rx_state_e                  next_state;
  logic [WAIT_W-1:0]          wait_cnt;
  logic [WAIT_W-1:0]          next_wait_cnt;

  // Only a TXDATA store can stall, and only on the registered full flag,
  // so a pop in the same cycle never makes room for a refused push.
  assign req_ready = !(req_write && (req_addr == ADDR_TXDATA) && tx_full);
  assign handshake = req_valid && req_ready;
  assign is_load   = handshake && !req_write;
  assign tx_push   = handshake && req_write && (req_addr == ADDR_TXDATA);
  assign tx_pop    = (tx_count != '0) && (gap_cnt == '0);
  assign rx_clear  = is_load && (req_addr == ADDR_RXDATA) && rx_valid;

  uart_tx_fifo #(
    .DEPTH (TX_DEPTH)
  ) u_tx_fifo (
    .clock     (clock),
    .reset     (reset),
    .push      (tx_push),
    .push_data (req_wdata),
    .pop       (tx_pop),
    .pop_data  (tx_pop_data),
    .full      (tx_full),
    .empty     (tx_empty),
    .count     (tx_count)
  );

  // Emit one queued character whenever the spacing counter has run out.
  always_ff @(posedge clock) begin
    if (reset) begin
      gap_cnt        <= '0;
      uart_out_valid <= 1'b0;
      uart_out_ch    <= '0;
    end else begin
      uart_out_valid <= tx_pop;
      if (tx_pop) begin
        uart_out_ch <= tx_pop_data;
        gap_cnt     <= GAP_RELOAD;
      end else if (gap_cnt != '0) begin
        gap_cnt <= gap_cnt - GAP_W'(1);
      end
    end
  end

  // Load data as seen at the handshake cycle.
  always_comb begin
    load_data = '0;
    case (req_addr)
      ADDR_STATUS: load_data = status_word(rx_valid, tx_empty, tx_full);
      ADDR_RXDATA: load_data = rx_valid ? {{(64 - CHAR_W){1'b0}}, rx_buf}
                                        : {{(64 - CHAR_W){1'b0}}, RX_NO_DATA};
      default:     load_data = '0;
    endcase
  end

  // Load responses appear exactly one cycle after the handshake.
  always_ff @(posedge clock) begin
    if (reset) begin
      rsp_valid <= 1'b0;
      rsp_rdata <= '0;
    end else begin
      rsp_valid <= is_load;
      if (is_load) begin
        rsp_rdata <= load_data;
      end
    end
  end

  // RX poll sequencing: wait POLL_GAP-1 cycles between polls while empty.
  always_comb begin
    next_state    = state;
    next_wait_cnt = wait_cnt;
    poll_load     = 1'b0;
    case (state)
      RX_IDLE: begin
        if (!rx_valid) begin
          next_state    = RX_WAIT;
          next_wait_cnt = WAIT_RELOAD;
        end
      end
      RX_WAIT: begin
        if (wait_cnt == '0) begin
          next_state = RX_POLL;
        end else begin
          next_wait_cnt = wait_cnt - WAIT_W'(1);
        end
      end
      RX_POLL: begin
        if (uart_in_ch != RX_NO_DATA) begin
          poll_load  = 1'b1;
          next_state = RX_IDLE;
        end else if (POLL_GAP == 1) begin
          next_state = RX_POLL;
        end else begin
          next_state    = RX_WAIT;
          next_wait_cnt = WAIT_RELOAD;
        end
      end
      default: begin
        next_state = RX_IDLE;
      end
    endcase
  end

  // FSM state, wait counter and the registered poll strobe.
  always_ff @(posedge clock) begin
    if (reset) begin
      state         <= RX_IDLE;
      wait_cnt      <= '0;
      uart_in_valid <= 1'b0;
    end else begin
      state         <= next_state;
      wait_cnt      <= next_wait_cnt;
      uart_in_valid <= (next_state == RX_POLL);
    end
  end

  // Receive buffer; polls only happen while empty, so load and clear never collide.
  always_ff @(posedge clock) begin
    if (reset) begin
      rx_valid <= 1'b0;
      rx_buf   <= '0;
    end else if (poll_load) begin
      rx_valid <= 1'b1;
      rx_buf   <= uart_in_ch;
    end else if (rx_clear) begin
      rx_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_uart_mmio_bridge.sv
// Directed bench for uart_mmio_bridge: one instance with default timing and
// one with a long TX gap to exercise the full-FIFO stall.
module tb_uart_mmio_bridge;

  localparam logic [3:0] A_TX = 4'h0;
  localparam logic [3:0] A_RX = 4'h4;
  localparam logic [3:0] A_ST = 4'h8;

  logic clock = 1'b0;
  logic reset = 1'b1;
  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;

  logic        a_req_valid = 1'b0;
  logic        a_req_write = 1'b0;
  logic [3:0]  a_req_addr  = 4'h0;
  logic [7:0]  a_req_wdata = 8'h00;
  logic        a_req_ready;
  logic        a_rsp_valid;
  logic [63:0] a_rsp_rdata;
  logic        a_out_valid;
  logic [7:0]  a_out_ch;
  logic        a_in_valid;
  logic [7:0]  a_in_ch = 8'hFF;

  logic        b_req_valid = 1'b0;
  logic        b_req_write = 1'b0;
  logic [3:0]  b_req_addr  = 4'h0;
  logic [7:0]  b_req_wdata = 8'h00;
  logic        b_req_ready;
  logic        b_rsp_valid;
  logic [63:0] b_rsp_rdata;
  logic        b_out_valid;
  logic [7:0]  b_out_ch;
  logic        b_in_valid;
  logic [7:0]  b_in_ch = 8'hFF;

  logic [7:0]  a_emit_ch [$];
  int          a_emit_cyc [$];
  logic [7:0]  b_emit_ch [$];
  int          b_emit_cyc [$];

  uart_mmio_bridge #(.TX_DEPTH(8), .TX_GAP(2), .POLL_GAP(4)) dut (
    .clock(clock), .reset(reset),
    .req_valid(a_req_valid), .req_write(a_req_write), .req_addr(a_req_addr),
    .req_wdata(a_req_wdata), .req_ready(a_req_ready),
    .rsp_valid(a_rsp_valid), .rsp_rdata(a_rsp_rdata),
    .uart_out_valid(a_out_valid), .uart_out_ch(a_out_ch),
    .uart_in_valid(a_in_valid), .uart_in_ch(a_in_ch)
  );

  uart_mmio_bridge #(.TX_DEPTH(8), .TX_GAP(100), .POLL_GAP(4)) dut_slow (
    .clock(clock), .reset(reset),
    .req_valid(b_req_valid), .req_write(b_req_write), .req_addr(b_req_addr),
    .req_wdata(b_req_wdata), .req_ready(b_req_ready),
    .rsp_valid(b_rsp_valid), .rsp_rdata(b_rsp_rdata),
    .uart_out_valid(b_out_valid), .uart_out_ch(b_out_ch),
    .uart_in_valid(b_in_valid), .uart_in_ch(b_in_ch)
  );

  always #5 clock = ~clock;

  always @(posedge clock) cyc <= cyc + 1;

  always @(negedge clock) begin
    if (a_out_valid) begin
      a_emit_ch.push_back(a_out_ch);
      a_emit_cyc.push_back(cyc);
    end
    if (b_out_valid) begin
      b_emit_ch.push_back(b_out_ch);
      b_emit_cyc.push_back(cyc);
    end
  end

  initial begin
    #400000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  task automatic a_store(input logic [3:0] addr, input logic [7:0] data,
                         input int max_wait, output int stall, output logic accepted);
    a_req_valid = 1'b1; a_req_write = 1'b1; a_req_addr = addr; a_req_wdata = data;
    stall = 0; accepted = 1'b0;
    for (int i = 0; i < max_wait; i++) begin
      #1;
      if (a_req_ready) begin
        accepted = 1'b1;
        @(posedge clock); #1;
        break;
      end
      stall++;
      @(posedge clock); #1;
    end
    a_req_valid = 1'b0; a_req_write = 1'b0;
  endtask

  task automatic b_store(input logic [3:0] addr, input logic [7:0] data,
                         input int max_wait, output int stall, output logic accepted);
    b_req_valid = 1'b1; b_req_write = 1'b1; b_req_addr = addr; b_req_wdata = data;
    stall = 0; accepted = 1'b0;
    for (int i = 0; i < max_wait; i++) begin
      #1;
      if (b_req_ready) begin
        accepted = 1'b1;
        @(posedge clock); #1;
        break;
      end
      stall++;
      @(posedge clock); #1;
    end
    b_req_valid = 1'b0; b_req_write = 1'b0;
  endtask

  task automatic a_load(input logic [3:0] addr, output logic [63:0] data, output logic valid);
    a_req_valid = 1'b1; a_req_write = 1'b0; a_req_addr = addr;
    @(posedge clock); #1;
    a_req_valid = 1'b0;
    valid = a_rsp_valid;
    data  = a_rsp_rdata;
  endtask

  task automatic b_load(input logic [3:0] addr, output logic [63:0] data, output logic valid);
    b_req_valid = 1'b1; b_req_write = 1'b0; b_req_addr = addr;
    @(posedge clock); #1;
    b_req_valid = 1'b0;
    valid = b_rsp_valid;
    data  = b_rsp_rdata;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    a_req_write = 1'b1; a_req_addr = A_TX;
    repeat (2) @(posedge clock);
    #1;
    checks++; if (a_rsp_valid !== 1'b0) begin errors++; $display("[TB] FAIL reset_rsp_valid: got %0b expected 0", a_rsp_valid); end
    checks++; if (a_rsp_rdata !== 64'h0) begin errors++; $display("[TB] FAIL reset_rsp_rdata: got %0h expected 0", a_rsp_rdata); end
    checks++; if (a_out_valid !== 1'b0 || a_out_ch !== 8'h00) begin errors++; $display("[TB] FAIL reset_uart_out: got %0b/%0h expected 0/0", a_out_valid, a_out_ch); end
    checks++; if (a_in_valid !== 1'b0 || b_in_valid !== 1'b0) begin errors++; $display("[TB] FAIL reset_uart_in_valid: got %0b/%0b expected 0/0", a_in_valid, b_in_valid); end
    checks++; if (a_req_ready !== 1'b1) begin errors++; $display("[TB] FAIL reset_req_ready: got %0b expected 1", a_req_ready); end
    a_req_write = 1'b0;
    reset = 1'b0;
  endtask

  task automatic test_status_idle();
    logic [63:0] d; logic v;
    a_load(A_ST, d, v);
    checks++; if (v !== 1'b1 || d !== 64'h2) begin errors++; $display("[TB] FAIL status_idle: got v=%0b d=%0h expected v=1 d=2", v, d); end
    @(posedge clock); #1;
    checks++; if (a_rsp_valid !== 1'b0) begin errors++; $display("[TB] FAIL rsp_one_cycle: got %0b expected 0", a_rsp_valid); end
    b_load(A_ST, d, v);
    checks++; if (v !== 1'b1 || d !== 64'h2) begin errors++; $display("[TB] FAIL status_idle_slow: got v=%0b d=%0h expected v=1 d=2", v, d); end
  endtask

  task automatic test_load_map();
    logic [63:0] d; logic v; int st; logic acc;
    a_load(A_TX, d, v);
    checks++; if (v !== 1'b1 || d !== 64'h0) begin errors++; $display("[TB] FAIL txdata_read: got v=%0b d=%0h expected v=1 d=0", v, d); end
    a_load(4'hC, d, v);
    checks++; if (v !== 1'b1 || d !== 64'h0) begin errors++; $display("[TB] FAIL unmapped_read: got v=%0b d=%0h expected v=1 d=0", v, d); end
    a_load(A_RX, d, v);
    checks++; if (v !== 1'b1 || d !== 64'hFF) begin errors++; $display("[TB] FAIL rxdata_empty: got v=%0b d=%0h expected v=1 d=ff", v, d); end
    a_store(A_ST, 8'h77, 5, st, acc);
    checks++; if (acc !== 1'b1 || st != 0 || a_rsp_valid !== 1'b0) begin errors++; $display("[TB] FAIL store_status_ignored: got acc=%0b stall=%0d rsp=%0b expected 1/0/0", acc, st, a_rsp_valid); end
    a_store(A_RX, 8'h55, 5, st, acc);
    checks++; if (acc !== 1'b1 || st != 0 || a_rsp_valid !== 1'b0) begin errors++; $display("[TB] FAIL store_rxdata_ignored: got acc=%0b stall=%0d rsp=%0b expected 1/0/0", acc, st, a_rsp_valid); end
    repeat (10) @(posedge clock);
    #1;
    checks++; if (a_emit_ch.size() != 0) begin errors++; $display("[TB] FAIL no_emit_from_other_offsets: got %0d emits expected 0", a_emit_ch.size()); end
  endtask

  task automatic test_back_to_back();
    int n0; int st0; int st1; logic acc0; logic acc1;
    n0 = a_emit_ch.size();
    a_store(A_TX, 8'h41, 5, st0, acc0);
    a_store(A_TX, 8'h42, 5, st1, acc1);
    checks++; if (!(acc0 === 1'b1 && acc1 === 1'b1 && st0 == 0 && st1 == 0)) begin errors++; $display("[TB] FAIL b2b_accept: got acc=%0b%0b stall=%0d/%0d expected 11 0/0", acc0, acc1, st0, st1); end
    for (int i = 0; i < 20 && a_emit_ch.size() < n0 + 2; i++) @(posedge clock);
    repeat (10) @(posedge clock);
    #1;
    checks++;
    if (a_emit_ch.size() != n0 + 2) begin
      errors++; $display("[TB] FAIL b2b_emit_count: got %0d expected %0d", a_emit_ch.size() - n0, 2);
    end else begin
      checks++; if (a_emit_ch[n0] !== 8'h41) begin errors++; $display("[TB] FAIL b2b_first_char: got %0h expected 41", a_emit_ch[n0]); end
      checks++; if (a_emit_ch[n0+1] !== 8'h42) begin errors++; $display("[TB] FAIL b2b_second_char: got %0h expected 42", a_emit_ch[n0+1]); end
      checks++; if (a_emit_cyc[n0+1] - a_emit_cyc[n0] != 2) begin errors++; $display("[TB] FAIL b2b_spacing: got %0d expected 2", a_emit_cyc[n0+1] - a_emit_cyc[n0]); end
    end
  endtask

  task automatic test_rx_poll();
    int polls; int poll_at [4]; int quiet; logic [63:0] d; logic v; logic seen;
    polls = 0; a_in_ch = 8'hFF;
    for (int i = 0; i < 200 && polls < 4; i++) begin
      @(negedge clock);
      if (a_in_valid) begin
        poll_at[polls] = cyc;
        polls++;
        if (polls == 4) a_in_ch = 8'h5A;
      end
    end
    @(posedge clock); #1;
    a_in_ch = 8'hFF;
    checks++;
    if (polls != 4) begin
      errors++; $display("[TB] FAIL rx_poll_timeout: got %0d polls expected 4", polls);
    end else begin
      checks++; if (poll_at[2] - poll_at[1] != 4) begin errors++; $display("[TB] FAIL rx_poll_spacing: got %0d expected 4", poll_at[2] - poll_at[1]); end
    end
    quiet = 0;
    repeat (12) begin
      @(negedge clock);
      if (a_in_valid) quiet++;
    end
    @(posedge clock); #1;
    checks++; if (quiet != 0) begin errors++; $display("[TB] FAIL rx_no_poll_when_full: got %0d polls expected 0", quiet); end
    a_load(A_ST, d, v);
    checks++; if (v !== 1'b1 || d !== 64'h6) begin errors++; $display("[TB] FAIL rx_status: got v=%0b d=%0h expected v=1 d=6", v, d); end
    a_load(A_RX, d, v);
    checks++; if (v !== 1'b1 || d !== 64'h5A) begin errors++; $display("[TB] FAIL rx_read_data: got v=%0b d=%0h expected v=1 d=5a", v, d); end
    a_load(A_RX, d, v);
    checks++; if (v !== 1'b1 || d !== 64'hFF) begin errors++; $display("[TB] FAIL rx_read_again: got v=%0b d=%0h expected v=1 d=ff", v, d); end
    seen = 1'b0;
    for (int i = 0; i < 20 && !seen; i++) begin
      @(negedge clock);
      if (a_in_valid) seen = 1'b1;
    end
    @(posedge clock); #1;
    checks++; if (seen !== 1'b1) begin errors++; $display("[TB] FAIL rx_poll_resumes: got %0b expected 1", seen); end
  endtask

  task automatic test_fifo_full();
    int nb0; int st; logic acc; logic [63:0] d; logic v;
    nb0 = b_emit_ch.size();
    for (int k = 0; k < 9; k++) begin
      b_store(A_TX, 8'h10 + 8'(k), 5, st, acc);
      checks++; if (acc !== 1'b1 || st != 0) begin errors++; $display("[TB] FAIL fill_store_%0d: got acc=%0b stall=%0d expected 1/0", k, acc, st); end
    end
    b_load(A_ST, d, v);
    checks++; if (v !== 1'b1 || d !== 64'h1) begin errors++; $display("[TB] FAIL full_status: got v=%0b d=%0h expected v=1 d=1", v, d); end
    b_store(A_ST, 8'h00, 5, st, acc);
    checks++; if (acc !== 1'b1 || st != 0) begin errors++; $display("[TB] FAIL full_other_store: got acc=%0b stall=%0d expected 1/0", acc, st); end
    b_store(A_TX, 8'h19, 300, st, acc);
    checks++; if (acc !== 1'b1 || st < 80 || st > 100) begin errors++; $display("[TB] FAIL full_stall: got acc=%0b stall=%0d expected 1 and 80..100", acc, st); end
    for (int i = 0; i < 1500 && b_emit_ch.size() < nb0 + 10; i++) @(posedge clock);
    #1;
    checks++;
    if (b_emit_ch.size() != nb0 + 10) begin
      errors++; $display("[TB] FAIL full_emit_count: got %0d expected 10", b_emit_ch.size() - nb0);
    end else begin
      for (int k = 0; k < 10; k++) begin
        checks++; if (b_emit_ch[nb0+k] !== 8'h10 + 8'(k)) begin errors++; $display("[TB] FAIL full_order_%0d: got %0h expected %0h", k, b_emit_ch[nb0+k], 8'h10 + 8'(k)); end
      end
      for (int k = 1; k < 10; k++) begin
        checks++; if (b_emit_cyc[nb0+k] - b_emit_cyc[nb0+k-1] != 100) begin errors++; $display("[TB] FAIL full_spacing_%0d: got %0d expected 100", k, b_emit_cyc[nb0+k] - b_emit_cyc[nb0+k-1]); end
      end
    end
  endtask

  task automatic test_reset_mid_op();
    int st; logic acc; logic [63:0] d; logic v; logic seen; int na; int nb;
    seen = 1'b0;
    for (int i = 0; i < 30 && !seen; i++) begin
      @(negedge clock);
      if (a_in_valid) begin
        seen = 1'b1;
        a_in_ch = 8'h33;
      end
    end
    @(posedge clock); #1;
    a_in_ch = 8'hFF;
    a_load(A_ST, d, v);
    checks++; if (v !== 1'b1 || d !== 64'h6) begin errors++; $display("[TB] FAIL premid_status: got v=%0b d=%0h expected v=1 d=6", v, d); end
    for (int k = 0; k < 5; k++) b_store(A_TX, 8'h70 + 8'(k), 5, st, acc);
    for (int k = 0; k < 5; k++) a_store(A_TX, 8'h61 + 8'(k), 5, st, acc);
    reset = 1'b1;
    @(posedge clock); #1;
    checks++; if (a_out_valid !== 1'b0 || b_out_valid !== 1'b0 || a_in_valid !== 1'b0 || a_rsp_valid !== 1'b0) begin
      errors++; $display("[TB] FAIL mid_reset_strobes: got out=%0b%0b in=%0b rsp=%0b expected all 0", a_out_valid, b_out_valid, a_in_valid, a_rsp_valid);
    end
    na = a_emit_ch.size();
    nb = b_emit_ch.size();
    @(posedge clock); #1;
    reset = 1'b0;
    a_load(A_ST, d, v);
    checks++; if (v !== 1'b1 || d !== 64'h2) begin errors++; $display("[TB] FAIL post_reset_status: got v=%0b d=%0h expected v=1 d=2", v, d); end
    b_load(A_ST, d, v);
    checks++; if (v !== 1'b1 || d !== 64'h2) begin errors++; $display("[TB] FAIL post_reset_status_slow: got v=%0b d=%0h expected v=1 d=2", v, d); end
    a_load(A_RX, d, v);
    checks++; if (v !== 1'b1 || d !== 64'hFF) begin errors++; $display("[TB] FAIL post_reset_rxdata: got v=%0b d=%0h expected v=1 d=ff", v, d); end
    repeat (150) @(posedge clock);
    #1;
    checks++; if (a_emit_ch.size() != na || b_emit_ch.size() != nb) begin
      errors++; $display("[TB] FAIL post_reset_no_emit: got %0d/%0d extra expected 0/0", a_emit_ch.size() - na, b_emit_ch.size() - nb);
    end
  endtask

  initial begin
    $display("[TB] starting uart_mmio_bridge bench");
    test_reset();
    test_status_idle();
    test_load_map();
    test_back_to_back();
    test_rx_poll();
    test_fifo_full();
    test_reset_mid_op();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
